// File: rtl/mult_result_buffer_pkg.sv
// ============================================================================
// Module      : mult_result_buffer_pkg
// Description : Shared types and constants for the multiplier result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_result_buffer_pkg;

  localparam logic [5:0] ZERO_REG    = 6'd31;
  localparam int         BMASK_W     = 4;
  localparam int         BR_MARKER_W = 3;
  localparam int         MULT_LAT    = 4;

  typedef struct packed {
    logic                   rec_en;
    logic [BR_MARKER_W-1:0] marker;
    logic                   mispre;
  } br_res_t;

  typedef struct packed {
    logic               live;
    logic [BMASK_W-1:0] bmask;
    logic [63:0]        product;
    logic [5:0]         dest;
    logic [63:0]        npc;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/mult_result_buffer_if.sv
// ============================================================================
// Module      : mult_result_buffer_if
// Description : Issue-credit, multiplier-result, branch and CDB signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_result_buffer_if;
  import mult_result_buffer_pkg::*;

  logic                   issue_fire;
  logic                   mult_issue_ok;
  logic                   mult_valid_in;
  logic [63:0]            mult_product_in;
  logic [5:0]             mult_dest_reg_in;
  logic [63:0]            mult_NPC_in;
  logic [BMASK_W-1:0]     mult_bmask_in;
  logic                   br_rec_en_1;
  logic                   br_rec_en_2;
  logic [BR_MARKER_W-1:0] br_marker_1;
  logic [BR_MARKER_W-1:0] br_marker_2;
  logic                   br_mispre_1;
  logic                   br_mispre_2;
  logic                   cdb_req;
  logic                   cdb_grant;
  logic [63:0]            cdb_value;
  logic [5:0]             cdb_dest_reg;
  logic [63:0]            cdb_NPC;
  logic [BMASK_W-1:0]     cdb_bmask;

  modport master (
    output issue_fire, mult_valid_in, mult_product_in, mult_dest_reg_in,
           mult_NPC_in, mult_bmask_in, br_rec_en_1, br_rec_en_2,
           br_marker_1, br_marker_2, br_mispre_1, br_mispre_2, cdb_grant,
    input  mult_issue_ok, cdb_req, cdb_value, cdb_dest_reg, cdb_NPC, cdb_bmask
  );

  modport slave (
    input  issue_fire, mult_valid_in, mult_product_in, mult_dest_reg_in,
           mult_NPC_in, mult_bmask_in, br_rec_en_1, br_rec_en_2,
           br_marker_1, br_marker_2, br_mispre_1, br_mispre_2, cdb_grant,
    output mult_issue_ok, cdb_req, cdb_value, cdb_dest_reg, cdb_NPC, cdb_bmask
  );

endinterface

`default_nettype wire

// File: rtl/mult_result_buffer_br_mask_update.sv
// ============================================================================
// Module      : br_mask_update
// Description : Branch recovery on one bmask: squash hit and resolved-bit clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_mask_update
  import mult_result_buffer_pkg::*;
(
  input  wire logic [BMASK_W-1:0] i_bmask,
  input  wire br_res_t            i_br1,
  input  wire br_res_t            i_br2,
  output logic                    o_hit,
  output logic [BMASK_W-1:0]      o_cleared
);

  // Markers at or above BMASK_W match no bit and so neither hit nor clear.
  always_comb begin
    o_hit     = 1'b0;
    o_cleared = i_bmask;
    for (int b = 0; b < BMASK_W; b++) begin
      if (i_br1.rec_en && (i_br1.marker == BR_MARKER_W'(b))) begin
        o_hit        = o_hit | (i_br1.mispre & i_bmask[b]);
        o_cleared[b] = 1'b0;
      end
      if (i_br2.rec_en && (i_br2.marker == BR_MARKER_W'(b))) begin
        o_hit        = o_hit | (i_br2.mispre & i_bmask[b]);
        o_cleared[b] = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_result_buffer.sv
// ============================================================================
// Module      : mult_result_buffer
// Description : FIFO of multiplier results awaiting CDB, with branch recovery
//               and issue-credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_result_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MULT_LAT = 4
) (
  input wire logic             clock,
  input wire logic             reset,
  mult_result_buffer_if.slave  bus
);
  import mult_result_buffer_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  entry_t                r_mem [DEPTH];
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [AW:0]           r_count;
  logic [MULT_LAT-1:0]   r_inflight;

  br_res_t               w_br1;
  br_res_t               w_br2;
  logic                  w_arr_hit;
  logic [BMASK_W-1:0]    w_arr_clr;
  logic [DEPTH-1:0]      w_ent_hit;
  logic [BMASK_W-1:0]    w_ent_clr [DEPTH];
  logic                  w_nonempty;
  logic                  w_head_live;
  logic                  w_head_hit;
  logic                  w_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;

  assign w_br1 = '{rec_en: bus.br_rec_en_1, marker: bus.br_marker_1, mispre: bus.br_mispre_1};
  assign w_br2 = '{rec_en: bus.br_rec_en_2, marker: bus.br_marker_2, mispre: bus.br_mispre_2};

  br_mask_update u_arr_upd (
    .i_bmask   (bus.mult_bmask_in),
    .i_br1     (w_br1),
    .i_br2     (w_br2),
    .o_hit     (w_arr_hit),
    .o_cleared (w_arr_clr)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    br_mask_update u_ent_upd (
      .i_bmask   (r_mem[gi].bmask),
      .i_br1     (w_br1),
      .i_br2     (w_br2),
      .o_hit     (w_ent_hit[gi]),
      .o_cleared (w_ent_clr[gi])
    );
  end

  // Credit counts queued entries plus results still inside the multiplier.
  assign bus.mult_issue_ok = (32'(r_count) + 32'($countones(r_inflight))) < DEPTH;
  assign w_issue           = bus.issue_fire & bus.mult_issue_ok;

  // Only results aligned with a tracked issue are accepted.
  assign w_push      = bus.mult_valid_in & r_inflight[MULT_LAT-1] & ~w_arr_hit;
  assign w_nonempty  = (r_count != '0);
  assign w_head_live = r_mem[r_head].live;
  assign w_head_hit  = w_ent_hit[r_head];
  assign w_req       = w_nonempty & w_head_live & ~w_head_hit;
  assign w_pop       = (w_req & bus.cdb_grant) | (w_nonempty & (~w_head_live | w_head_hit));

  always_comb begin
    bus.cdb_req      = w_req;
    bus.cdb_value    = '0;
    bus.cdb_dest_reg = ZERO_REG;
    bus.cdb_NPC      = '0;
    bus.cdb_bmask    = '0;
    if (w_req) begin
      bus.cdb_value    = r_mem[r_head].product;
      bus.cdb_dest_reg = r_mem[r_head].dest;
      bus.cdb_NPC      = r_mem[r_head].npc;
      bus.cdb_bmask    = w_ent_clr[r_head];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_inflight <= {r_inflight[MULT_LAT-2:0], w_issue};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].bmask <= w_ent_clr[i];
        if (w_ent_hit[i]) begin
          r_mem[i].live <= 1'b0;
        end
      end
      if (w_pop) begin
        r_mem[r_head].live <= 1'b0;
        r_head             <= r_head + c_ptr_one;
      end
      // A write to the slot being popped (full buffer) takes precedence.
      if (w_push) begin
        r_mem[r_tail] <= '{live: 1'b1, bmask: w_arr_clr, product: bus.mult_product_in,
                           dest: bus.mult_dest_reg_in, npc: bus.mult_NPC_in};
        r_tail        <= r_tail + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_result_buffer.sv
// ============================================================================
// Module      : tb_mult_result_buffer
// Description : Directed and randomized bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_result_buffer;

  localparam int DEPTH = 8;
  localparam int LAT   = 4;

  typedef struct {
    bit          live;
    logic [3:0]  bm;
    logic [63:0] p;
    logic [5:0]  d;
    logic [63:0] n;
  } ment_t;

  typedef struct {
    int          at;
    logic [63:0] p;
    logic [5:0]  d;
    logic [63:0] n;
    logic [3:0]  b;
  } sch_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   allow_untracked = 1'b0;

  ment_t       mq[$];
  int          iss[$];
  sch_t        sched[$];
  logic [63:0] bcast[$];
  logic [63:0] plist[$];

  mult_result_buffer_if bus ();

  mult_result_buffer #(.DEPTH(DEPTH), .MULT_LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(logic [3:0] m);
    bit h = 1'b0;
    if (bus.br_rec_en_1 && bus.br_mispre_1 && int'(bus.br_marker_1) < 4 && m[bus.br_marker_1[1:0]]) h = 1'b1;
    if (bus.br_rec_en_2 && bus.br_mispre_2 && int'(bus.br_marker_2) < 4 && m[bus.br_marker_2[1:0]]) h = 1'b1;
    return h;
  endfunction

  function automatic logic [3:0] clr(logic [3:0] m);
    logic [3:0] r = m;
    if (bus.br_rec_en_1 && int'(bus.br_marker_1) < 4) r[bus.br_marker_1[1:0]] = 1'b0;
    if (bus.br_rec_en_2 && int'(bus.br_marker_2) < 4) r[bus.br_marker_2[1:0]] = 1'b0;
    return r;
  endfunction

  function automatic bit model_ok();
    return (mq.size() + iss.size()) < DEPTH;
  endfunction

  task automatic idle();
    bus.issue_fire  = 1'b0;
    bus.br_rec_en_1 = 1'b0; bus.br_marker_1 = '0; bus.br_mispre_1 = 1'b0;
    bus.br_rec_en_2 = 1'b0; bus.br_marker_2 = '0; bus.br_mispre_2 = 1'b0;
  endtask

  task automatic br1(logic [2:0] mk, logic mis);
    bus.br_rec_en_1 = 1'b1; bus.br_marker_1 = mk; bus.br_mispre_1 = mis;
  endtask

  task automatic br2(logic [2:0] mk, logic mis);
    bus.br_rec_en_2 = 1'b1; bus.br_marker_2 = mk; bus.br_mispre_2 = mis;
  endtask

  task automatic do_issue(logic [63:0] p, logic [3:0] b);
    sch_t s;
    s.at = cyc + LAT; s.p = p; s.b = b;
    s.d = 6'($urandom_range(0, 30));
    s.n = {$urandom, $urandom};
    bus.issue_fire = 1'b1;
    sched.push_back(s);
    plist.push_back(p);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"},   64'(bus.cdb_req), 64'd0);
    chk({tag, "_value"}, bus.cdb_value, 64'd0);
    chk({tag, "_dest"},  64'(bus.cdb_dest_reg), 64'd31);
    chk({tag, "_npc"},   bus.cdb_NPC, 64'd0);
    chk({tag, "_bmask"}, 64'(bus.cdb_bmask), 64'd0);
    chk({tag, "_ok"},    64'(bus.mult_issue_ok), 64'd1);
  endtask

  // One clock cycle: drive the multiplier output, compare at negedge, advance model.
  task automatic tick();
    bit er, eok, trk;
    ment_t e;
    bus.mult_valid_in = 1'b0; bus.mult_product_in = '0; bus.mult_dest_reg_in = '0;
    bus.mult_NPC_in = '0; bus.mult_bmask_in = '0;
    foreach (sched[i]) begin
      if (sched[i].at == cyc) begin
        bus.mult_valid_in = 1'b1; bus.mult_product_in = sched[i].p;
        bus.mult_dest_reg_in = sched[i].d; bus.mult_NPC_in = sched[i].n;
        bus.mult_bmask_in = sched[i].b;
      end
    end
    @(negedge clock);
    eok = model_ok();
    er  = !reset && mq.size() > 0 && mq[0].live && !hit(mq[0].bm);
    chk("cdb_req", 64'(bus.cdb_req), 64'(er));
    chk("issue_ok", 64'(bus.mult_issue_ok), 64'(eok));
    chk("cdb_value", bus.cdb_value, er ? mq[0].p : 64'd0);
    chk("cdb_dest", 64'(bus.cdb_dest_reg), er ? 64'(mq[0].d) : 64'd31);
    chk("cdb_npc", bus.cdb_NPC, er ? mq[0].n : 64'd0);
    chk("cdb_bmask", 64'(bus.cdb_bmask), er ? 64'(clr(mq[0].bm)) : 64'd0);
    if (bus.issue_fire) chk("proto_issue_ok", 64'(bus.mult_issue_ok), 64'd1);
    if (bus.cdb_req === 1'b1 && bus.cdb_grant) bcast.push_back(bus.cdb_value);
    if (reset) begin
      mq.delete(); iss.delete();
    end else begin
      trk = iss.size() > 0 && (iss[0] + LAT == cyc);
      if (bus.mult_valid_in && !allow_untracked) chk("proto_valid_tracked", 64'(trk), 64'd1);
      if (mq.size() > 0 && (!mq[0].live || hit(mq[0].bm) || bus.cdb_grant)) void'(mq.pop_front());
      foreach (mq[i]) begin
        if (hit(mq[i].bm)) mq[i].live = 1'b0;
        mq[i].bm = clr(mq[i].bm);
      end
      if (trk) begin
        void'(iss.pop_front());
        if (bus.mult_valid_in && !hit(bus.mult_bmask_in)) begin
          e.live = 1'b1; e.bm = clr(bus.mult_bmask_in); e.p = bus.mult_product_in;
          e.d = bus.mult_dest_reg_in; e.n = bus.mult_NPC_in;
          mq.push_back(e);
        end
      end
      if (bus.issue_fire && eok) iss.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int issued;
    logic [63:0] p2;
    idle();
    bus.cdb_grant = 1'b0;
    bus.mult_valid_in = 1'b0; bus.mult_product_in = '0; bus.mult_dest_reg_in = '0;
    bus.mult_NPC_in = '0; bus.mult_bmask_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Three back-to-back issues with grant held high.
    bus.cdb_grant = 1'b1;
    bcast.delete();
    do_issue(64'd6, 4'b0000);  tick();
    do_issue(64'd15, 4'b0000); tick();
    do_issue(64'd42, 4'b0000); tick();
    idle(); ticks(6);
    chk("b2b_count", 64'(bcast.size()), 64'd3);
    if (bcast.size() == 3) begin
      chk("b2b_first", bcast[0], 64'd6);
      chk("b2b_second", bcast[1], 64'd15);
      chk("b2b_third", bcast[2], 64'd42);
    end
    chk("b2b_empty_req", 64'(bus.cdb_req), 64'd0);

    // Fill until credit runs out, then drain in order.
    bus.cdb_grant = 1'b0;
    plist.delete(); bcast.delete();
    issued = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (bus.mult_issue_ok) begin
        do_issue({$urandom, $urandom}, 4'b0000);
        issued++;
      end
      tick();
    end
    idle();
    chk("stall_issued", 64'(issued), 64'd8);
    chk("stall_ok_low", 64'(bus.mult_issue_ok), 64'd0);
    bus.cdb_grant = 1'b1;
    ticks(8);
    bus.cdb_grant = 1'b0;
    chk("drain_count", 64'(bcast.size()), 64'd8);
    if (bcast.size() == 8 && plist.size() == 8)
      foreach (bcast[i]) chk("drain_order", bcast[i], plist[i]);
    tick();

    // Mispredict on marker 0 kills the first and third entries.
    bcast.delete();
    do_issue({$urandom, $urandom}, 4'b0001); tick();
    p2 = {$urandom, $urandom};
    do_issue(p2, 4'b0010); tick();
    do_issue({$urandom, $urandom}, 4'b0001); tick();
    idle(); ticks(4);
    br1(3'd0, 1'b1); tick();
    idle(); bus.cdb_grant = 1'b1; ticks(4);
    chk("squash_count", 64'(bcast.size()), 64'd1);
    if (bcast.size() == 1) chk("squash_survivor", bcast[0], p2);

    // Arrival squashed in its own cycle, then arrival with only a clear.
    bus.cdb_grant = 1'b0;
    do_issue({$urandom, $urandom}, 4'b0100); tick();
    idle(); ticks(3);
    br1(3'd2, 1'b1); tick();
    idle(); #2;
    chk("arr_squash_req", 64'(bus.cdb_req), 64'd0);
    tick();
    do_issue({$urandom, $urandom}, 4'b0100); tick();
    idle(); ticks(3);
    br1(3'd2, 1'b0); tick();
    idle(); #2;
    chk("arr_clear_req", 64'(bus.cdb_req), 64'd1);
    chk("arr_clear_bmask", 64'(bus.cdb_bmask), 64'd0);
    bus.cdb_grant = 1'b1; ticks(2);

    // Dual channel: marker 1 resolves correct, marker 5 matches nothing.
    bus.cdb_grant = 1'b0; bcast.delete();
    do_issue({$urandom, $urandom}, 4'b0010); tick();
    do_issue({$urandom, $urandom}, 4'b0010); tick();
    idle(); ticks(5);
    br1(3'd1, 1'b0); br2(3'd5, 1'b1); #2;
    chk("dual_req", 64'(bus.cdb_req), 64'd1);
    chk("dual_bmask", 64'(bus.cdb_bmask), 64'd0);
    tick();
    idle(); bus.cdb_grant = 1'b1; ticks(3);
    chk("dual_bcast", 64'(bcast.size()), 64'd2);

    // Asynchronous reset with five queued and two in flight.
    bus.cdb_grant = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_issue({$urandom, $urandom}, 4'($urandom_range(0, 15)));
      tick();
    end
    idle(); ticks(2);
    chk("pre_reset_req", 64'(bus.cdb_req), 64'd1);
    reset = 1'b1; mq.delete(); iss.delete(); #1;
    chk_reset_outputs("async_reset");
    allow_untracked = 1'b1;
    tick();
    reset = 1'b0;
    ticks(3);
    allow_untracked = 1'b0;
    chk("post_reset_req", 64'(bus.cdb_req), 64'd0);
    chk("post_reset_ok", 64'(bus.mult_issue_ok), 64'd1);

    // Randomized soak against the model.
    for (int k = 0; k < 400; k++) begin
      idle();
      bus.cdb_grant = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0 && model_ok())
        do_issue({$urandom, $urandom}, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) br1(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) br2(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end
    idle(); bus.cdb_grant = 1'b1; ticks(16);
    chk("soak_empty_req", 64'(bus.cdb_req), 64'd0);
    chk("soak_ok", 64'(bus.mult_issue_ok), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
